// File: rtl/axis_reg_slice_pipe.sv
// AXI-Stream register-slice pipeline: STAGES cascaded skid-buffer slices carrying data+last.
// Optional completed-packet counter on pkt_cnt when AXIS_PKT_CNT_EN is defined.

module axis_reg_slice #(
  parameter int unsigned BEAT_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BEAT_W-1:0] in_beat,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BEAT_W-1:0] out_beat,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] main_q, main_d;
  logic [BEAT_W-1:0] skid_q, skid_d;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              ready_q, ready_d;
  logic              in_acc;
  logic              out_acc;

  assign in_acc  = in_valid && ready_q;
  assign out_acc = main_valid_q && out_ready;

  // State and storage registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  // Next-state and datapath steering
  always_comb begin
    state_d      = state_q;
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_acc) begin
          main_d       = in_beat;
          main_valid_d = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (in_acc && out_acc) begin
          main_d = in_beat;
        end else if (in_acc) begin
          skid_d       = in_beat;
          skid_valid_d = 1'b1;
          state_d      = FULL;
        end else if (out_acc) begin
          main_valid_d = 1'b0;
          state_d      = EMPTY;
        end
      end
      FULL: begin
        // ready is low here, so only the drain side can move
        if (out_acc) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
          state_d      = ONE;
        end
      end
      default: begin
        state_d      = EMPTY;
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
    endcase
    ready_d = !skid_valid_d;
  end

  assign in_ready  = ready_q;
  assign out_beat  = main_q;
  assign out_valid = main_valid_q;

endmodule

module axis_reg_slice_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
`ifdef AXIS_PKT_CNT_EN
  ,
  output logic [31:0]       pkt_cnt
`endif
);

  localparam int unsigned BEAT_W = DATA_W + 1;

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $fatal(1, "axis_reg_slice_pipe: STAGES must be 1..8");
  end
  if (DATA_W < 1 || DATA_W > 512) begin : g_bad_width
    $fatal(1, "axis_reg_slice_pipe: DATA_W must be 1..512");
  end

  // Link i feeds slice i; link STAGES is the master side
  logic [STAGES:0][BEAT_W-1:0] link_beat;
  logic [STAGES:0]             link_valid;
  logic [STAGES:0]             link_ready;

  assign link_beat[0]       = {s_last, s_data};
  assign link_valid[0]      = s_valid;
  assign s_ready            = link_ready[0];
  assign link_ready[STAGES] = m_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    axis_reg_slice #(
      .BEAT_W(BEAT_W)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .in_beat  (link_beat[i]),
      .in_valid (link_valid[i]),
      .in_ready (link_ready[i]),
      .out_beat (link_beat[i+1]),
      .out_valid(link_valid[i+1]),
      .out_ready(link_ready[i+1])
    );
  end

  assign m_data  = link_beat[STAGES][DATA_W-1:0];
  assign m_last  = link_beat[STAGES][DATA_W];
  assign m_valid = link_valid[STAGES];

`ifdef AXIS_PKT_CNT_EN
  // Counts output handshakes that close a packet; wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt <= '0;
    end else if (m_valid && m_ready && m_last) begin
      pkt_cnt <= pkt_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_reg_slice_pipe.sv
// Directed bench for axis_reg_slice_pipe (8-bit/2-stage) plus a randomized 32-bit/3-stage instance.
// Exercises pkt_cnt only when AXIS_PKT_CNT_EN is defined.

module tb_axis_reg_slice_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  s_data, m_data;
  logic        s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [31:0] r_s_data, r_m_data;
  logic        r_s_valid, r_s_ready, r_s_last, r_m_valid, r_m_ready, r_m_last;
`ifdef AXIS_PKT_CNT_EN
  logic [31:0] pkt_cnt, r_pkt_cnt;
`endif

  int checks = 0;
  int errors = 0;

  axis_reg_slice_pipe #(.DATA_W(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
`ifdef AXIS_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  axis_reg_slice_pipe #(.DATA_W(32), .STAGES(3)) dut3 (
    .clk(clk), .rst(rst),
    .s_data(r_s_data), .s_valid(r_s_valid), .s_ready(r_s_ready), .s_last(r_s_last),
    .m_data(r_m_data), .m_valid(r_m_valid), .m_ready(r_m_ready), .m_last(r_m_last)
`ifdef AXIS_PKT_CNT_EN
    , .pkt_cnt(r_pkt_cnt)
`endif
  );

  task automatic test_reset();
    rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    r_s_valid = 1'b0; r_s_data = '0; r_s_last = 1'b0; r_m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0) begin
        errors++;
        $display("FAIL reset_vals cyc%0d: s_ready=%b m_valid=%b m_data=%h m_last=%b, required 0 0 00 0",
                 i, s_ready, m_valid, m_data, m_last);
      end
    end
`ifdef AXIS_PKT_CNT_EN
    checks++;
    if (pkt_cnt !== 32'd0 || r_pkt_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_pkt_cnt: got %0d/%0d, required 0", pkt_cnt, r_pkt_cnt);
    end
`endif
    rst = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: s_ready=%b, required 0", s_ready);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || r_s_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge: s_ready=%b m_valid=%b r_s_ready=%b, required 1 0 1",
               s_ready, m_valid, r_s_ready);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    s_data = 8'hA5; s_valid = 1'b1; s_last = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: m_valid=%b after 1 cycle, required 0", m_valid);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_last !== 1'b1) begin
      errors++;
      $display("FAIL single_out: m_valid=%b m_data=%h m_last=%b, required 1 a5 1", m_valid, m_data, m_last);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_once: m_valid=%b, required 0", m_valid);
    end
  endtask

  task automatic test_stream();
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      checks++;
      if (c >= 2 && c <= 17) begin
        if (m_valid !== 1'b1 || m_data !== 8'(c - 2)) begin
          errors++;
          $display("FAIL stream_out c%0d: m_valid=%b m_data=%h, required 1 %h", c, m_valid, m_data, 8'(c - 2));
        end
      end else if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_idle c%0d: m_valid=%b, required 0", c, m_valid);
      end
      if (c < 16) begin
        checks++;
        if (s_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready c%0d: s_ready=%b, required 1", c, s_ready);
        end
      end
      m_ready = 1'b1;
      s_valid = (c < 16);
      s_data  = 8'(c);
      s_last  = 1'b0;
    end
    s_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int rcvd = 0;
    for (int c = 0; c < 80 && rcvd < 16; c++) begin
      @(negedge clk);
      if (c <= 13) begin
        checks++;
        if (s_ready !== ((c >= 5 && c <= 12) ? 1'b0 : 1'b1)) begin
          errors++;
          $display("FAIL bp_ready c%0d: s_ready=%b, required %b", c, s_ready, (c >= 5 && c <= 12) ? 1'b0 : 1'b1);
        end
      end
      if (c >= 4 && c <= 11) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h01) begin
          errors++;
          $display("FAIL bp_stable c%0d: m_valid=%b m_data=%h, required 1 01", c, m_valid, m_data);
        end
      end
      m_ready = !(c >= 3 && c <= 10);
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 8'(rcvd) || m_last !== (rcvd == 15)) begin
          errors++;
          $display("FAIL bp_order beat%0d: m_data=%h m_last=%b, required %h %b", rcvd, m_data, m_last, 8'(rcvd), rcvd == 15);
        end
        rcvd++;
      end
      s_valid = (sent < 16);
      s_data  = 8'(sent);
      s_last  = (sent == 15);
      if (s_valid && s_ready) sent++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (rcvd != 16 || sent != 16 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: sent=%0d rcvd=%0d m_valid=%b, required 16 16 0", sent, rcvd, m_valid);
    end
  endtask

  task automatic test_random();
    logic [32:0] q[$];
    logic [32:0] exp_beat, prev_beat;
    logic        prev_stall = 1'b0;
    logic        acc_prev = 1'b0;
    int          sent = 0;
    int          rcvd = 0;
    for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (r_m_valid !== 1'b1 || {r_m_last, r_m_data} !== prev_beat) begin
          errors++;
          $display("FAIL rnd_stable c%0d: m_valid=%b beat=%h, required 1 %h", c, r_m_valid, {r_m_last, r_m_data}, prev_beat);
        end
      end
      checks++;
      if (sent - rcvd > 6) begin
        errors++;
        $display("FAIL rnd_occupancy c%0d: %0d beats in flight, required <= 6", c, sent - rcvd);
      end
      r_m_ready = 1'($urandom_range(1, 0));
      if (r_m_valid && r_m_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra c%0d: beat %h with empty scoreboard, required none", c, {r_m_last, r_m_data});
        end else begin
          exp_beat = q.pop_front();
          if ({r_m_last, r_m_data} !== exp_beat) begin
            errors++;
            $display("FAIL rnd_data beat%0d: got %h, required %h", rcvd, {r_m_last, r_m_data}, exp_beat);
          end
        end
        rcvd++;
      end
      prev_stall = r_m_valid && !r_m_ready;
      prev_beat  = {r_m_last, r_m_data};
      if (!r_s_valid || acc_prev) begin
        r_s_valid = (sent < 1000) && 1'($urandom_range(1, 0));
        r_s_data  = $urandom;
        r_s_last  = 1'($urandom_range(1, 0));
      end
      acc_prev = r_s_valid && r_s_ready;
      if (acc_prev) begin
        q.push_back({r_s_last, r_s_data});
        sent++;
      end
    end
    @(negedge clk);
    r_s_valid = 1'b0;
    r_m_ready = 1'b0;
    checks++;
    if (rcvd != 1000 || q.size() != 0) begin
      errors++;
      $display("FAIL rnd_total: rcvd=%0d pending=%0d, required 1000 0", rcvd, q.size());
    end
  endtask

  task automatic test_pkt_reset();
    int lens[5] = '{1, 3, 4, 1, 7};
    int idx = 0;
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    foreach (lens[p]) begin
      for (int b = 0; b < lens[p]; b++) begin
        s_valid = 1'b1; s_data = 8'(idx); s_last = (b == lens[p] - 1);
        idx++;
        @(negedge clk);
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL pkt_drain: m_valid=%b, required 0", m_valid);
    end
`ifdef AXIS_PKT_CNT_EN
    checks++;
    if (pkt_cnt !== 32'd5) begin
      errors++;
      $display("FAIL pkt_cnt_five: got %0d, required 5", pkt_cnt);
    end
`endif
    s_valid = 1'b1; s_data = 8'h40; s_last = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    s_data = 8'h41;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h40) begin
      errors++;
      $display("FAIL midpkt_out: m_valid=%b m_data=%h, required 1 40", m_valid, m_data);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: m_valid=%b s_ready=%b m_data=%h, required 0 0 00", m_valid, s_ready, m_data);
    end
`ifdef AXIS_PKT_CNT_EN
    checks++;
    if (pkt_cnt !== 32'd0) begin
      errors++;
      $display("FAIL pkt_cnt_reset: got %0d, required 0", pkt_cnt);
    end
`endif
    s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_partial c%0d: m_valid=%b, required 0", i, m_valid);
      end
    end
    s_valid = 1'b1; s_data = 8'h50; s_last = 1'b0;
    @(negedge clk);
    s_data = 8'h51; s_last = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h50 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL restart_b0: m_valid=%b m_data=%h m_last=%b, required 1 50 0", m_valid, m_data, m_last);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h51 || m_last !== 1'b1) begin
      errors++;
      $display("FAIL restart_b1: m_valid=%b m_data=%h m_last=%b, required 1 51 1", m_valid, m_data, m_last);
    end
    @(negedge clk);
`ifdef AXIS_PKT_CNT_EN
    checks++;
    if (pkt_cnt !== 32'd1) begin
      errors++;
      $display("FAIL pkt_cnt_restart: got %0d, required 1", pkt_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_random();
    test_pkt_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_reg_slice_pipe.md
Name: axis_reg_slice_pipe

Overview:
Parametrised AXI-Stream register-slice pipeline; successor to the fixed 8-bit stream register.
- Carries data width DATA_W through STAGES cascaded skid-buffer slices.
- Honours m_ready backpressure with full throughput, no combinational ready path, and no beat loss or duplication.
- Sits between stream producers and consumers to break timing paths on data, valid and ready.

Parameters:
- DATA_W, 8, payload width in bits (1..512).
- STAGES, 2, number of cascaded slices (1..8); 0 is illegal and stops elaboration.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- s_data  input  DATA_W  upstream payload.
- s_valid  input  1  upstream beat valid.
- s_ready  output  1  block can accept; registered.
- s_last  input  1  upstream end-of-packet marker.
- m_data  output  DATA_W  downstream payload; registered.
- m_valid  output  1  downstream beat valid; registered.
- m_ready  input  1  downstream can accept.
- m_last  output  1  downstream end-of-packet marker; registered.
- pkt_cnt  output  32  completed-packet count; present only with AXIS_PKT_CNT_EN.

Behaviour:
- Reset values while rst=0: s_ready=0, m_valid=0, m_data=0, m_last=0, all internal main/skid registers and valids cleared, pkt_cnt=0.
- After rst deasserts, s_ready rises on the first rising clk edge.
- Beat acceptance: a beat is transferred when valid&&ready on a clock edge, at each interface and between slices. data and last always travel together.
- Each slice has a main register and a skid register, and three states:
  - EMPTY: input accept -> load main, go to ONE.
  - ONE:
    - in accept & out accept -> reload main, stay in ONE.
    - in accept & !out accept -> load skid, go to FULL; slice ready<=0.
    - no in & out accept -> go to EMPTY.
  - FULL:
    - out accept -> main<=skid, go to ONE; slice ready<=1.
    - no input is possible in FULL because ready=0.
- Slice ready is registered as !skid_valid; its out-valid is main_valid. No combinational path from m_ready to s_ready.
- Latency: STAGES cycles from s_valid&&s_ready to m_valid with m_ready held high.
- Throughput: one beat per cycle when m_ready=1 continuously.
- Stability: while m_valid=1 && m_ready=0, m_data and m_last hold constant. m_valid never drops without a handshake.
- Ordering: strictly FIFO. Maximum occupancy is 2*STAGES beats. Stalls propagate upstream one slice per cycle.
- Simultaneous events: input and output accept on the same edge in the same slice -> pass-through with no state change (ONE->ONE).
- Reset mid-operation: all in-flight beats are discarded immediately. No partial packet is emitted after reset; the bench must restart packets.
- s_data/s_last are ignored when s_valid=0. m_data contents are don't-care when m_valid=0 but are held, not cleared.

Optional Feature:
AXIS_PKT_CNT_EN
- Defined:
  - pkt_cnt port exists; increments by 1 on each output handshake with m_last=1.
  - Wraps 0xFFFFFFFF -> 0.
  - Cleared by reset.
  - No effect on datapath timing.
- Undefined: port and counter are absent; datapath is identical.

Test Plan:
- Reset release, STAGES=2: rst low 3 cycles then high -> s_ready=0 during reset, 1 one edge later; m_valid=0 throughout.
- Single beat s_data=0xA5, s_last=1, m_ready=1 -> m_valid=1 with m_data=0xA5, m_last=1 exactly 2 cycles later, for one cycle only.
- Streaming 0x00..0x0F back-to-back, m_ready=1 -> output 0x00..0x0F on 16 consecutive cycles, no bubbles, s_ready stays 1.
- Backpressure: 16-beat stream, m_ready=0 for cycles 3-10:
  - s_ready drops after 4 beats are held (2*STAGES).
  - m_data stays stable while stalled.
  - All 16 beats arrive in order, none lost or duplicated.
- Random s_valid/m_ready (50%), 1000 beats, DATA_W=32, STAGES=3 -> scoreboard matches data/last order exactly; no combinational ready path (lint check).
- AXIS_PKT_CNT_EN, five packets of lengths 1,3,4,1,7, then rst mid-packet -> pkt_cnt=5 before reset, 0 after; m_valid=0 immediately on rst assertion.
